// File: rtl/capture_buffer_ctrl.sv
// capture_buffer_ctrl: multi-channel sample capture buffer.
// Fills on sample strobes, streams out over valid/ready after a start delay.
module capture_buffer_ctrl #(
  parameter int WORD_WIDTH = 24,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 3,
  parameter int READ_DELAY = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         begin_write,
  input  logic                         continuous,
  input  logic                         sample,
  input  logic [NUM_CH*WORD_WIDTH-1:0] sample_data,
  input  logic                         begin_read,
  input  logic                         abort,
  input  logic                         rd_ready,
  output logic [NUM_CH*WORD_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         rd_last,
  output logic [ADDR_WIDTH-1:0]        rd_index,
  output logic                         write_complete,
  output logic                         busy,
  output logic                         overrun
);

  localparam int DW    = NUM_CH * WORD_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (READ_DELAY > 0) ? $clog2(READ_DELAY + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0] C_LAST =
    (READ_DELAY > 0) ? CW'(READ_DELAY - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FULL,
    S_DELAY,
    S_READ
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cont_q, cont_d;
  logic                  ovr_q, ovr_d;
  logic                  wc_q, wc_d;
  logic                  busy_q, busy_d;
  logic                  fdone_q, fdone_d;

  logic                  p1_v_q, p1_v_d;
  logic [ADDR_WIDTH-1:0] p1_idx_q, p1_idx_d;
  logic                  p1_last_q, p1_last_d;
  logic [DW-1:0]         mem_rdata;
  logic [DW-1:0]         mem [DEPTH];

  logic [DW-1:0]         fdata_q [2];
  logic [DW-1:0]         fdata_d [2];
  logic [ADDR_WIDTH-1:0] fidx_q [2];
  logic [ADDR_WIDTH-1:0] fidx_d [2];
  logic [1:0]            flast_q, flast_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic                  fwp_q, fwp_d;
  logic                  frp_q, frp_d;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  last_xfer;
  logic                  mem_we;
  logic [1:0]            occ_left;

  assign rd_valid       = (fcnt_q != 2'd0);
  assign rd_data        = rd_valid ? fdata_q[frp_q] : '0;
  assign rd_index       = rd_valid ? fidx_q[frp_q] : '0;
  assign rd_last        = rd_valid & flast_q[frp_q];
  assign write_complete = wc_q;
  assign busy           = busy_q;
  assign overrun        = ovr_q;

  assign pop       = rd_valid & rd_ready;
  assign push      = p1_v_q;
  assign last_xfer = pop & flast_q[frp_q];
  assign occ_left  = fcnt_q + {1'b0, p1_v_q} - {1'b0, pop};
  assign issue     = (state_q == S_READ) & ~fdone_q &
                     (occ_left < 2'd2) & ~abort;
  assign mem_we    = (state_q == S_FILL) & sample & ~abort;

  // Next-state: control FSM, read prefetch and 2-entry output skid.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    cont_d    = cont_q;
    ovr_d     = ovr_q;
    wc_d      = wc_q;
    fdone_d   = fdone_q;
    p1_v_d    = issue;
    p1_idx_d  = p1_idx_q;
    p1_last_d = p1_last_q;
    fdata_d   = fdata_q;
    fidx_d    = fidx_q;
    flast_d   = flast_q;
    fcnt_d    = fcnt_q + {1'b0, push} - {1'b0, pop};
    fwp_d     = fwp_q ^ push;
    frp_d     = frp_q ^ pop;

    if (push) begin
      fdata_d[fwp_q] = mem_rdata;
      fidx_d[fwp_q]  = p1_idx_q;
      flast_d[fwp_q] = p1_last_q;
    end

    if (issue) begin
      p1_idx_d  = rd_addr_q;
      p1_last_d = (rd_addr_q == A_LAST);
      rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
      if (rd_addr_q == A_LAST) fdone_d = 1'b1;
    end

    if (abort) begin
      state_d = S_IDLE;
      wc_d    = 1'b0;
      fcnt_d  = 2'd0;
      fwp_d   = 1'b0;
      frp_d   = 1'b0;
      p1_v_d  = 1'b0;
    end else begin
      if (sample && (state_q inside {S_FULL, S_DELAY, S_READ}))
        ovr_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (begin_write) begin
            state_d   = S_FILL;
            wr_addr_d = '0;
            cont_d    = continuous;
            ovr_d     = 1'b0;
          end
        end
        S_FILL: begin
          if (sample) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            if (wr_addr_q == A_LAST) begin
              state_d = S_FULL;
              wc_d    = 1'b1;
            end
          end
        end
        S_FULL: begin
          if (begin_read) begin
            if (READ_DELAY == 0) begin
              state_d   = S_READ;
              rd_addr_d = '0;
              fdone_d   = 1'b0;
            end else begin
              state_d = S_DELAY;
              cnt_d   = '0;
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == C_LAST) begin
            state_d   = S_READ;
            rd_addr_d = '0;
            fdone_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_READ: begin
          if (last_xfer) begin
            wc_d = 1'b0;
            if (cont_q) begin
              state_d   = S_FILL;
              wr_addr_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // Sample memory: not cleared by reset, one-cycle registered read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= sample_data;
    if (issue) mem_rdata <= mem[rd_addr_q];
  end

  // Control, prefetch and skid registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      cont_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wc_q      <= 1'b0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
      p1_v_q    <= 1'b0;
      p1_idx_q  <= '0;
      p1_last_q <= 1'b0;
      fdata_q   <= '{default: '0};
      fidx_q    <= '{default: '0};
      flast_q   <= '0;
      fcnt_q    <= '0;
      fwp_q     <= 1'b0;
      frp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      cont_q    <= cont_d;
      ovr_q     <= ovr_d;
      wc_q      <= wc_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
      p1_v_q    <= p1_v_d;
      p1_idx_q  <= p1_idx_d;
      p1_last_q <= p1_last_d;
      fdata_q   <= fdata_d;
      fidx_q    <= fidx_d;
      flast_q   <= flast_d;
      fcnt_q    <= fcnt_d;
      fwp_q     <= fwp_d;
      frp_q     <= frp_d;
    end
  end

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// tb_capture_buffer_ctrl: directed bench for capture_buffer_ctrl.
// Default instance plus a wide, zero-delay, 16-deep instance.
module tb_capture_buffer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_bw, a_cont, a_smp, a_br, a_abort, a_rdy;
  logic [47:0] a_sd, a_rd;
  logic        a_rv, a_rl, a_wc, a_busy, a_ovr;
  logic [2:0]  a_idx;

  logic        b_bw, b_cont, b_smp, b_br, b_abort, b_rdy;
  logic [95:0] b_sd, b_rd;
  logic        b_rv, b_rl, b_wc, b_busy, b_ovr;
  logic [3:0]  b_idx;

  int n_cmp = 0;
  int n_err = 0;

  capture_buffer_ctrl u_dut (
    .clk(clk), .reset(reset),
    .begin_write(a_bw), .continuous(a_cont),
    .sample(a_smp), .sample_data(a_sd),
    .begin_read(a_br), .abort(a_abort),
    .rd_ready(a_rdy), .rd_data(a_rd),
    .rd_valid(a_rv), .rd_last(a_rl),
    .rd_index(a_idx), .write_complete(a_wc),
    .busy(a_busy), .overrun(a_ovr)
  );

  capture_buffer_ctrl #(
    .WORD_WIDTH(24), .NUM_CH(4),
    .ADDR_WIDTH(4), .READ_DELAY(0)
  ) u_dut6 (
    .clk(clk), .reset(reset),
    .begin_write(b_bw), .continuous(b_cont),
    .sample(b_smp), .sample_data(b_sd),
    .begin_read(b_br), .abort(b_abort),
    .rd_ready(b_rdy), .rd_data(b_rd),
    .rd_valid(b_rv), .rd_last(b_rl),
    .rd_index(b_idx), .write_complete(b_wc),
    .busy(b_busy), .overrun(b_ovr)
  );

  task automatic check(input string tag,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] pk(input logic [23:0] v);
    return {~v, v};
  endfunction

  function automatic logic [95:0] pkb(input int i);
    logic [95:0] r;
    for (int c = 0; c < 4; c++)
      r[c*24 +: 24] = 24'(c * 65536 + i + 1);
    return r;
  endfunction

  task automatic fill_a(input logic [23:0] base,
                        input logic cont,
                        input logic arm);
    if (arm) begin
      a_bw   = 1'b1;
      a_cont = cont;
      a_smp  = 1'b1;
      a_sd   = 48'hDEAD_BEEF_0BAD;
      step();
      a_bw = 1'b0;
      check("arm_busy", 128'(a_busy), 128'(1));
      check("arm_ovr_clr", 128'(a_ovr), 128'(0));
    end
    for (int i = 0; i < 8; i++) begin
      check("fill_wc", 128'(a_wc), 128'(0));
      a_smp = 1'b1;
      a_sd  = pk(base + 24'(i));
      step();
    end
    a_smp = 1'b0;
    check("fill_wc_set", 128'(a_wc), 128'(1));
  endtask

  task automatic read_a(input logic [23:0] base,
                        input int mode,
                        input logic pulse,
                        input logic exp_busy);
    int lat;
    int cyc;
    int beat;
    logic stalled;
    logic [47:0] sd;
    logic [2:0] si;
    a_rdy = 1'b1;
    a_br  = 1'b1;
    step();
    a_br = 1'b0;
    lat  = 0;
    while (!a_rv && lat < 40) begin
      step();
      lat++;
    end
    check("rd_lat", 128'(lat), 128'(9));
    cyc  = 0;
    beat = 0;
    sd   = '0;
    si   = '0;
    while (beat < 8 && cyc < 100) begin
      a_rdy   = (mode == 0) || (cyc % 3 == 0);
      a_smp   = pulse && (cyc == 2);
      a_sd    = '1;
      stalled = 1'b0;
      if (mode == 0) check("rv_cont", 128'(a_rv), 128'(1));
      if (a_rv && a_rdy) begin
        check("rd_idx", 128'(a_idx), 128'(beat));
        check("rd_data", 128'(a_rd), 128'(pk(base + 24'(beat))));
        check("rd_last", 128'(a_rl), 128'(beat == 7));
        beat++;
      end else if (a_rv) begin
        stalled = 1'b1;
        sd = a_rd;
        si = a_idx;
      end
      step();
      cyc++;
      if (stalled) begin
        check("stall_v", 128'(a_rv), 128'(1));
        check("stall_d", 128'(a_rd), 128'(sd));
        check("stall_i", 128'(a_idx), 128'(si));
      end
    end
    a_smp = 1'b0;
    a_rdy = 1'b0;
    check("beats", 128'(beat), 128'(8));
    check("post_rv", 128'(a_rv), 128'(0));
    check("post_wc", 128'(a_wc), 128'(0));
    check("post_busy", 128'(a_busy), 128'(exp_busy));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b0;
    a_bw = 0; a_cont = 0; a_smp = 0; a_br = 0;
    a_abort = 0; a_rdy = 0; a_sd = '0;
    b_bw = 0; b_cont = 0; b_smp = 0; b_br = 0;
    b_abort = 0; b_rdy = 0; b_sd = '0;
    step();
    step();
    check("rst_rv", 128'(a_rv), 128'(0));
    check("rst_busy", 128'(a_busy), 128'(0));
    check("rst_wc", 128'(a_wc), 128'(0));
    check("rst_ovr", 128'(a_ovr), 128'(0));
    check("rst_data", 128'(a_rd), 128'(0));
    check("rst_last", 128'(a_rl), 128'(0));
    reset = 1'b1;
    step();

    // one-shot capture and read-out
    fill_a(24'h000001, 1'b0, 1'b1);
    read_a(24'h000001, 0, 1'b0, 1'b0);

    // backpressure
    fill_a(24'h000100, 1'b0, 1'b1);
    read_a(24'h000100, 1, 1'b0, 1'b0);

    // continuous: two rounds
    fill_a(24'h000200, 1'b1, 1'b1);
    read_a(24'h000200, 0, 1'b0, 1'b1);
    fill_a(24'h000300, 1'b1, 1'b0);
    read_a(24'h000300, 0, 1'b0, 1'b1);
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    check("cont_abort_busy", 128'(a_busy), 128'(0));

    // overrun in FULL and READ
    fill_a(24'h000400, 1'b0, 1'b1);
    a_smp = 1'b1;
    a_sd  = '1;
    step();
    a_smp = 1'b0;
    check("ovr_full", 128'(a_ovr), 128'(1));
    read_a(24'h000400, 0, 1'b1, 1'b0);
    check("ovr_hold", 128'(a_ovr), 128'(1));

    // abort mid-read after 3 beats
    fill_a(24'h000500, 1'b0, 1'b1);
    a_smp = 1'b1;
    step();
    a_smp = 1'b0;
    a_rdy = 1'b1;
    a_br  = 1'b1;
    step();
    a_br = 1'b0;
    lat  = 0;
    while (!a_rv && lat < 40) begin
      step();
      lat++;
    end
    check("ab_lat", 128'(lat), 128'(9));
    step();
    step();
    step();
    check("ab_idx3", 128'(a_idx), 128'(3));
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    a_rdy   = 1'b0;
    check("ab_rv", 128'(a_rv), 128'(0));
    check("ab_last", 128'(a_rl), 128'(0));
    check("ab_wc", 128'(a_wc), 128'(0));
    check("ab_busy", 128'(a_busy), 128'(0));
    check("ab_data", 128'(a_rd), 128'(0));
    check("ab_ovr", 128'(a_ovr), 128'(1));
    step();
    step();
    check("ab_rv_later", 128'(a_rv), 128'(0));

    // reset mid-fill
    a_bw = 1'b1;
    step();
    a_bw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_smp = 1'b1;
      a_sd  = pk(24'h0000AA);
      step();
    end
    a_smp = 1'b0;
    check("pre_rst_busy", 128'(a_busy), 128'(1));
    reset = 1'b0;
    #1;
    check("rst_fill_busy", 128'(a_busy), 128'(0));
    check("rst_fill_wc", 128'(a_wc), 128'(0));
    check("rst_fill_rv", 128'(a_rv), 128'(0));
    #2;
    reset = 1'b1;
    step();
    fill_a(24'h000600, 1'b0, 1'b1);
    read_a(24'h000600, 1, 1'b0, 1'b0);

    // wide, zero-delay, 16-deep instance
    b_bw = 1'b1;
    step();
    b_bw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_smp = 1'b1;
      b_sd  = pkb(i);
      step();
    end
    b_smp = 1'b0;
    check("b_wc", 128'(b_wc), 128'(1));
    b_rdy = 1'b1;
    b_br  = 1'b1;
    step();
    b_br = 1'b0;
    lat  = 0;
    while (!b_rv && lat < 40) begin
      step();
      lat++;
    end
    check("b_lat", 128'(lat), 128'(2));
    for (int i = 0; i < 16; i++) begin
      check("b_rv", 128'(b_rv), 128'(1));
      check("b_idx", 128'(b_idx), 128'(i));
      check("b_data", 128'(b_rd), 128'(pkb(i)));
      check("b_last", 128'(b_rl), 128'(i == 15));
      step();
    end
    b_rdy = 1'b0;
    check("b_post_rv", 128'(b_rv), 128'(0));
    check("b_post_busy", 128'(b_busy), 128'(0));
    check("b_post_wc", 128'(b_wc), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
